mem_arbiter: RTL and testbench

//  Shares the single AXI block-transfer port between icache refill, dcache writeback and dcache refill.

---
 rtl/mem_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Registered arbiter sharing one AXI block-transfer port between icache refill,
// dcache writeback and dcache refill. Define MEM_ARB_RR_EN for dcache/icache round-robin.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 64,
    parameter int BLOCK_WIDTH = 512
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_ic_rd_req,
    input  logic [ADDR_WIDTH-1:0]  i_ic_rd_addr,
    input  logic                   i_dc_wb_req,
    input  logic [ADDR_WIDTH-1:0]  i_dc_wb_addr,
    input  logic [BLOCK_WIDTH-1:0] i_dc_wb_data,
    input  logic                   i_dc_rd_req,
    input  logic [ADDR_WIDTH-1:0]  i_dc_rd_addr,
    input  logic                   i_axi_done,
    input  logic [BLOCK_WIDTH-1:0] i_data_block,
    output logic [ADDR_WIDTH-1:0]  o_axi_addr,
    output logic                   o_axi_write_start,
    output logic                   o_axi_read_start,
    output logic [BLOCK_WIDTH-1:0] o_data_block,
    output logic [BLOCK_WIDTH-1:0] o_rd_block,
    output logic                   o_ic_rd_done,
    output logic                   o_dc_wb_done,
    output logic                   o_dc_rd_done,
    output logic                   o_busy,
    output logic [2:0]             o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD_D = 3'd2,
        S_RD_I = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                 r_state;
    logic [ADDR_WIDTH-1:0]  r_axi_addr;
    logic                   r_write_start;
    logic                   r_read_start;
    logic [BLOCK_WIDTH-1:0] r_data_block;
    logic [BLOCK_WIDTH-1:0] r_rd_block;
    logic                   r_ic_rd_done;
    logic                   r_dc_wb_done;
    logic                   r_dc_rd_done;

    logic                   w_dc_any;
    logic                   w_any_req;
    logic                   w_pick_ic;
    state_t                 w_grant;
    logic [ADDR_WIDTH-1:0]  w_grant_addr;

    assign w_dc_any  = i_dc_wb_req | i_dc_rd_req;
    assign w_any_req = w_dc_any | i_ic_rd_req;

`ifdef MEM_ARB_RR_EN
    // Set when the dcache class won the most recent grant; icache wins ties while set.
    logic r_last_dc;

    assign w_pick_ic = i_ic_rd_req & (~w_dc_any | r_last_dc);
`else
    assign w_pick_ic = i_ic_rd_req & ~w_dc_any;
`endif

    // Within dcache an eviction always goes out before the refill that needs its slot.
    always_comb begin
        w_grant      = S_RD_D;
        w_grant_addr = i_dc_rd_addr;
        if (w_pick_ic) begin
            w_grant      = S_RD_I;
            w_grant_addr = i_ic_rd_addr;
        end else if (i_dc_wb_req) begin
            w_grant      = S_WR;
            w_grant_addr = i_dc_wb_addr;
        end
    end

    always_ff @(posedge i_clk or negedge i_arst) begin
        if (!i_arst) begin
            r_state       <= S_IDLE;
            r_axi_addr    <= '0;
            r_write_start <= 1'b0;
            r_read_start  <= 1'b0;
            r_data_block  <= '0;
            r_rd_block    <= '0;
            r_ic_rd_done  <= 1'b0;
            r_dc_wb_done  <= 1'b0;
            r_dc_rd_done  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_dc     <= 1'b1;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= w_grant;
                        r_axi_addr <= w_grant_addr;
                        if (w_grant == S_WR) begin
                            r_data_block  <= i_dc_wb_data;
                            r_write_start <= 1'b1;
                        end else begin
                            r_read_start  <= 1'b1;
                        end
`ifdef MEM_ARB_RR_EN
                        r_last_dc <= ~w_pick_ic;
`endif
                    end
                end
                S_WR: begin
                    if (i_axi_done) begin
                        r_state       <= S_RESP;
                        r_write_start <= 1'b0;
                        r_dc_wb_done  <= 1'b1;
                    end
                end
                S_RD_D: begin
                    if (i_axi_done) begin
                        r_state      <= S_RESP;
                        r_read_start <= 1'b0;
                        r_rd_block   <= i_data_block;
                        r_dc_rd_done <= 1'b1;
                    end
                end
                S_RD_I: begin
                    if (i_axi_done) begin
                        r_state      <= S_RESP;
                        r_read_start <= 1'b0;
                        r_rd_block   <= i_data_block;
                        r_ic_rd_done <= 1'b1;
                    end
                end
                S_RESP: begin
                    // Done pulse lasts exactly this one cycle; requester drops its req meanwhile.
                    r_state      <= S_IDLE;
                    r_ic_rd_done <= 1'b0;
                    r_dc_wb_done <= 1'b0;
                    r_dc_rd_done <= 1'b0;
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_write_start <= 1'b0;
                    r_read_start  <= 1'b0;
                    r_ic_rd_done  <= 1'b0;
                    r_dc_wb_done  <= 1'b0;
                    r_dc_rd_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_axi_addr        = r_axi_addr;
    assign o_axi_write_start = r_write_start;
    assign o_axi_read_start  = r_read_start;
    assign o_data_block      = r_data_block;
    assign o_rd_block        = r_rd_block;
    assign o_ic_rd_done      = r_ic_rd_done;
    assign o_dc_wb_done      = r_dc_wb_done;
    assign o_dc_rd_done      = r_dc_rd_done;
    assign o_busy            = (r_state != S_IDLE);
    assign o_dbg_state       = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: requester/AXI-slave driver tasks and a grant scoreboard.
module tb_mem_arbiter;

  localparam int AW = 64;
  localparam int BW = 512;
  localparam int EW = 2 + AW + BW;
  localparam logic [1:0] K_WR  = 2'd1;
  localparam logic [1:0] K_RDD = 2'd2;
  localparam logic [1:0] K_RDI = 2'd3;

  logic          clk;
  logic          arst_n;
  logic          ic_rd_req;
  logic [AW-1:0] ic_rd_addr;
  logic          dc_wb_req;
  logic [AW-1:0] dc_wb_addr;
  logic [BW-1:0] dc_wb_data;
  logic          dc_rd_req;
  logic [AW-1:0] dc_rd_addr;
  logic          axi_done;
  logic [BW-1:0] data_block;
  logic [AW-1:0] axi_addr;
  logic          axi_write_start;
  logic          axi_read_start;
  logic [BW-1:0] o_data_block;
  logic [BW-1:0] rd_block;
  logic          ic_rd_done;
  logic          dc_wb_done;
  logic          dc_rd_done;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_checks;
  int n_fails;
  int wait_cycles;
  logic [EW-1:0] exp_q[$];

  mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WIDTH(BW)) dut (
    .i_clk             (clk),
    .i_arst            (arst_n),
    .i_ic_rd_req       (ic_rd_req),
    .i_ic_rd_addr      (ic_rd_addr),
    .i_dc_wb_req       (dc_wb_req),
    .i_dc_wb_addr      (dc_wb_addr),
    .i_dc_wb_data      (dc_wb_data),
    .i_dc_rd_req       (dc_rd_req),
    .i_dc_rd_addr      (dc_rd_addr),
    .i_axi_done        (axi_done),
    .i_data_block      (data_block),
    .o_axi_addr        (axi_addr),
    .o_axi_write_start (axi_write_start),
    .o_axi_read_start  (axi_read_start),
    .o_data_block      (o_data_block),
    .o_rd_block        (rd_block),
    .o_ic_rd_done      (ic_rd_done),
    .o_dc_wb_done      (dc_wb_done),
    .o_dc_rd_done      (dc_rd_done),
    .o_busy            (busy),
    .o_dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d fails=%0d", n_checks, n_fails);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd_blk();
    logic [BW-1:0] b;
    for (int i = 0; i < BW / 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  task automatic push_exp(input logic [1:0] k, input logic [AW-1:0] a, input logic [BW-1:0] d);
    exp_q.push_back({k, a, d});
  endtask

  task automatic check_idle_quiet(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_dones"}, {ic_rd_done, dc_wb_done, dc_rd_done}, 0);
    check_eq({tag, "_starts"}, {axi_write_start, axi_read_start}, 0);
  endtask

  // AXI slave + requester driver: waits for a grant, checks it against the scoreboard,
  // holds for lat cycles, completes it, then checks the done pulse.
  // drop_mode: 0 keep requests, 1 drop the served request on done, 2 drop all on done.
  task automatic serve(input int lat, input int drop_mode, input bit drop_mid);
    logic [EW-1:0] e;
    logic [1:0]    k;
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    bit            seen;
    check_eq("sb_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    k = e[EW-1 -: 2];
    a = e[BW +: AW];
    d = e[BW-1:0];
    seen = 0;
    wait_cycles = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      wait_cycles++;
      if (axi_write_start || axi_read_start) seen = 1;
    end
    check_eq("start_seen", seen, 1);
    if (!seen) return;
    check_eq("start_write", axi_write_start, k == K_WR);
    check_eq("start_read", axi_read_start, k != K_WR);
    check_eq("grant_addr", axi_addr, a);
    if (k == K_WR) check_eq("wr_data", o_data_block, d);
    check_eq("busy_xfer", busy, 1);
    for (int i = 0; i < lat; i++) begin
      if (drop_mid && i == lat / 2) begin
        ic_rd_req = 0;
        dc_wb_req = 0;
        dc_rd_req = 0;
      end
      @(negedge clk);
      check_eq("hold_addr", axi_addr, a);
      check_eq("hold_starts", {axi_write_start, axi_read_start}, {k == K_WR, k != K_WR});
      if (k == K_WR) check_eq("hold_data", o_data_block, d);
    end
    axi_done = 1;
    data_block = (k == K_WR) ? rnd_blk() : d;
    @(negedge clk);
    axi_done = 0;
    data_block = rnd_blk();
    check_eq("done_ic", ic_rd_done, k == K_RDI);
    check_eq("done_wb", dc_wb_done, k == K_WR);
    check_eq("done_rd", dc_rd_done, k == K_RDD);
    check_eq("resp_starts", {axi_write_start, axi_read_start}, 0);
    check_eq("resp_busy", busy, 1);
    if (k != K_WR) check_eq("rd_block", rd_block, d);
    if (drop_mode == 2) begin
      ic_rd_req = 0;
      dc_wb_req = 0;
      dc_rd_req = 0;
    end else if (drop_mode == 1) begin
      case (k)
        K_WR:    dc_wb_req = 0;
        K_RDD:   dc_rd_req = 0;
        default: ic_rd_req = 0;
      endcase
    end
    @(negedge clk);
    check_eq("post_dones", {ic_rd_done, dc_wb_done, dc_rd_done}, 0);
    check_eq("post_busy", busy, 0);
  endtask

  initial begin
    logic [BW-1:0] blk;
    n_checks = 0;
    n_fails = 0;
    arst_n = 0;
    ic_rd_req = 0; ic_rd_addr = '0;
    dc_wb_req = 0; dc_wb_addr = '0; dc_wb_data = '0;
    dc_rd_req = 0; dc_rd_addr = '0;
    axi_done = 0; data_block = '0;
    repeat (2) @(negedge clk);
    check_idle_quiet("reset");
    check_eq("reset_addr", axi_addr, 0);
    check_eq("reset_rd_block", rd_block, 0);
    check_eq("reset_wr_data", o_data_block, 0);
    arst_n = 1;
    @(negedge clk);

    // reset mid icache refill: abort, no done
    ic_rd_addr = 64'h800;
    ic_rd_req = 1;
    repeat (3) @(negedge clk);
    check_eq("pre_abort_read", axi_read_start, 1);
    #2;
    arst_n = 0;
    ic_rd_req = 0;
    @(negedge clk);
    check_idle_quiet("abort");
    check_eq("abort_addr", axi_addr, 0);
    arst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_idle_quiet("after_abort");
    end

    // icache refill alone
    blk = {64{8'hA5}};
    ic_rd_addr = 64'h1000;
    ic_rd_req = 1;
    push_exp(K_RDI, 64'h1000, blk);
    serve(20, 1, 0);
    check_eq("start_latency", wait_cycles, 1);

    // writeback + dcache refill together: eviction first, 2 idle cycles between
    dc_wb_addr = 64'h2040;
    dc_wb_data = {64{8'h55}};
    dc_rd_addr = 64'h3000;
    dc_wb_req = 1;
    dc_rd_req = 1;
    push_exp(K_WR, 64'h2040, {64{8'h55}});
    push_exp(K_RDD, 64'h3000, rnd_blk());
    serve(5, 1, 0);
    check_eq("wr_start_latency", wait_cycles, 1);
    serve(4, 1, 0);
    check_eq("idle_gap", wait_cycles, 1);

    // icache vs dcache contention
    ic_rd_addr = 64'h4000;
    dc_rd_addr = 64'h4100;
    ic_rd_req = 1;
    dc_rd_req = 1;
`ifdef MEM_ARB_RR_EN
    push_exp(K_RDI, 64'h4000, rnd_blk());
    push_exp(K_RDD, 64'h4100, rnd_blk());
`else
    push_exp(K_RDD, 64'h4100, rnd_blk());
    push_exp(K_RDI, 64'h4000, rnd_blk());
`endif
    serve($urandom_range(1, 6), 1, 0);
    serve($urandom_range(1, 6), 1, 0);

    // spurious done while idle
    @(negedge clk);
    axi_done = 1;
    @(negedge clk);
    axi_done = 0;
    check_idle_quiet("spurious");
    check_eq("spurious_state", dbg_state, 0);
    @(negedge clk);
    check_idle_quiet("spurious_2");

    // request dropped mid-transfer still completes
    dc_rd_addr = 64'h7000;
    dc_rd_req = 1;
    push_exp(K_RDD, 64'h7000, rnd_blk());
    serve(6, 1, 1);

    // back-to-back with both classes held high
    ic_rd_addr = 64'h5000;
    dc_rd_addr = 64'h6000;
    ic_rd_req = 1;
    dc_rd_req = 1;
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i % 2 == 0) push_exp(K_RDI, 64'h5000, rnd_blk());
      else            push_exp(K_RDD, 64'h6000, rnd_blk());
`else
      push_exp(K_RDD, 64'h6000, rnd_blk());
`endif
    end
    for (int i = 0; i < 10; i++) begin
      serve($urandom_range(1, 4), (i == 9) ? 2 : 0, 0);
      if (i < 9) check_eq("b2b_gap", wait_cycles, 1);
    end
    repeat (2) @(negedge clk);
    check_idle_quiet("final");
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
